spi_crc_accum: RTL and testbench
================================

// Module: spi_crc_accum
// PURPOSE
//  Sequential CRC accumulator for SPI frames: accepts WDATA-bit words through a valid/ready handshake,
//  splits each word into WCODE-bit chunks (MSB chunk first) and folds one chunk per clock into a running
//  remainder using the chunk-wise CRC evaluator. Sits between the SPI shift register and the frame
//  controller: generates the TX CRC, or checks the RX CRC against a reference at end of frame.
// PARAMETERS
//  WDATA  8        word width from the SPI shifter; must be a multiple of WCODE
//  WCODE  4        chunk width per CRC step; must be >= WPOLY-1
//  WPOLY  4        generator width incl. leading 1; CRC width = WPOLY-1
//  POLY   4'b1011  generator polynomial x^3+x+1
//  INIT   '0       remainder loaded on reset and on i_start (WPOLY-1 bits)
// PORTS
//  i_clk      in   1          clock, rising edge
//  i_rst      in   1          asynchronous reset, active-high
//  i_start    in   1          synchronous frame start: clear remainder to INIT, abort any word in progress
//  i_valid    in   1          i_data/i_last/i_crc_ref valid
//  o_ready    out  1          block can accept a word (state IDLE)
//  i_data     in   WDATA      data word, MSB first
//  i_last     in   1          word is the last one of the frame
//  i_crc_ref  in   WPOLY-1    expected CRC, sampled with the last word (RX check)
//  o_crc      out  WPOLY-1    running/final remainder
//  o_done     out  1          one-cycle pulse: frame CRC final in o_crc
//  o_match    out  1          o_crc == sampled i_crc_ref; valid from o_done, held until next i_start
// BEHAVIOUR
//  Reset (async): state=IDLE, o_crc=INIT, o_done=0, o_match=0, chunk counter=0; o_ready=1 once i_rst drops.
//  Arithmetic: N=WDATA/WCODE, K=WPOLY-1. Per chunk c: R' = (R*x^WCODE + c*x^K) mod POLY over GF(2),
//   computed as evaluator(data = c ^ {R, (WCODE-K)'b0}, crc_in = 0); keep the low K bits.
//   Result over a frame = (message * x^K) mod POLY, message bits MSB first.
//  FSM: IDLE -> BUSY on i_valid && o_ready (edge t): latch word, i_last, i_crc_ref; counter=0.
//   BUSY: one chunk per edge (t+1 .. t+N), o_ready=0; after chunk N-1 return to IDLE.
//   If latched i_last: on edge t+N also set o_done=1 (for one cycle) and o_match=(R'==crc_ref).
//   Throughput: one word every N+1 cycles; o_ready high again in the cycle after edge t+N.
//  o_crc updates after every chunk (intermediate values visible); final value held until i_start.
//  i_start: highest priority. In BUSY: abort word, R=INIT, state=IDLE, no o_done. Clears o_match.
//   i_start && i_valid in IDLE same cycle: R=INIT and the word is accepted, folded onto INIT.
//  i_valid while o_ready=0: ignored (no acceptance); upstream holds its word.
//  Words after a last word without i_start: continue accumulating from the held remainder.
//  Reset asserted mid-word: immediate return to reset values; partial word discarded.
// TESTING
//  1. POLY=1011, frame {0x01} last -> o_crc=3'b011, o_done one cycle at edge t+2, o_ready low 2 cycles.
//  2. Frame {0x80} last -> o_crc=3'b011; frame {0x81} last, i_crc_ref=000 -> o_crc=000, o_match=1.
//  3. Frame {0x01,0x00} (last on 2nd), i_crc_ref=3'b110 -> o_crc=110, o_match=1; ref 3'b111 -> o_match=0.
//  4. i_start one cycle after accepting 0xFF -> no o_done, o_crc=INIT, o_ready=1 next cycle.
//  5. i_valid held high with back-to-back words -> exactly one acceptance per N+1 cycles, no lost/dup words.
//  6. Async i_rst pulse mid-BUSY (between edges) -> outputs reset immediately; next frame {0x01} -> 3'b011.

Source files
------------

// File: rtl/spi_crc_accum.sv
// Chunk-serial CRC accumulator for SPI frames: folds each accepted word into the running
// remainder WCODE bits per clock, MSB chunk first, and flags the final CRC of each frame.
module spi_crc_accum #(
  parameter int                WDATA = 8,
  parameter int                WCODE = 4,
  parameter int                WPOLY = 4,
  parameter logic [WPOLY-1:0]  POLY  = 4'b1011,
  parameter logic [WPOLY-2:0]  INIT  = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WDATA-1:0] i_data,
  input  logic             i_last,
  input  logic [WPOLY-2:0] i_crc_ref,
  output logic [WPOLY-2:0] o_crc,
  output logic             o_done,
  output logic             o_match
);

  localparam int N  = WDATA / WCODE;
  localparam int K  = WPOLY - 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WDATA-1:0] word;
  logic             last_q;
  logic [K-1:0]     ref_q;
  logic [K-1:0]     crc_next;

  // One chunk through the evaluator: the remainder is pre-aligned onto the chunk MSBs,
  // then the WCODE bits are divided out with a zero-seeded remainder.
  function automatic logic [K-1:0] crc_step(input logic [K-1:0] r, input logic [WCODE-1:0] c);
    logic [WCODE-1:0] d;
    logic [K-1:0]     x;
    logic             fb;
    d = c ^ (WCODE'(r) << (WCODE - K));
    x = '0;
    for (int i = WCODE - 1; i >= 0; i--) begin
      fb = x[K-1] ^ d[i];
      x  = x << 1;
      if (fb) x = x ^ POLY[K-1:0];
    end
    return x;
  endfunction

  always_comb begin
    crc_next = crc_step(o_crc, word[WDATA-1 -: WCODE]);
  end

  assign o_ready = (state == IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      word    <= '0;
      last_q  <= 1'b0;
      ref_q   <= '0;
      o_crc   <= INIT;
      o_done  <= 1'b0;
      o_match <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (i_start) begin
        o_crc   <= INIT;
        o_match <= 1'b0;
        state   <= IDLE;
        if (state == IDLE && i_valid) begin
          word   <= i_data;
          last_q <= i_last;
          ref_q  <= i_crc_ref;
          cnt    <= CW'(N - 1);
          state  <= BUSY;
        end
      end else begin
        case (state)
          IDLE: begin
            if (i_valid) begin
              word   <= i_data;
              last_q <= i_last;
              ref_q  <= i_crc_ref;
              cnt    <= CW'(N - 1);
              state  <= BUSY;
            end
          end
          BUSY: begin
            o_crc <= crc_next;
            word  <= word << WCODE;
            if (cnt == '0) begin
              state <= IDLE;
              if (last_q) begin
                o_done  <= 1'b1;
                o_match <= (crc_next == ref_q);
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_crc_accum.sv
// Bench for spi_crc_accum: directed frames with literal CRCs plus random traffic checked
// every cycle against a polynomial-division model of the accumulated message.
module tb_spi_crc_accum;

  localparam int          WD   = 8;
  localparam int          WC   = 4;
  localparam int          K    = 3;
  localparam int          N    = WD / WC;
  localparam logic [3:0]  POLY = 4'b1011;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_start;
  logic          i_valid;
  logic          o_ready;
  logic [WD-1:0] i_data;
  logic          i_last;
  logic [K-1:0]  i_crc_ref;
  logic [K-1:0]  o_crc;
  logic          o_done;
  logic          o_match;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  spi_crc_accum dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_last(i_last), .i_crc_ref(i_crc_ref), .o_crc(o_crc),
    .o_done(o_done), .o_match(o_match)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Remainder of a GF(2) polynomial by long division.
  function automatic logic [K-1:0] pmod(input logic [63:0] v);
    for (int i = 63; i >= K; i--)
      if (v[i]) v = v ^ (64'(POLY) << (i - K));
    return v[K-1:0];
  endfunction

  // Behavioural model: remainder of (all message bits so far) * x^K, with the word
  // being folded in exposed chunk by chunk.
  logic          m_busy, m_last, m_done, m_match;
  int            m_j;
  logic [WD-1:0] m_word;
  logic [K-1:0]  m_ref, m_base, m_crc;

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m_busy = 0; m_last = 0; m_done = 0; m_match = 0; m_j = 0;
      m_word = '0; m_ref = '0; m_base = '0; m_crc = '0;
    end else begin
      logic was_busy;
      was_busy = m_busy;
      m_done   = 0;
      if (i_start) begin
        m_crc = '0; m_match = 0; m_busy = 0;
      end else if (was_busy) begin
        m_j++;
        m_crc = pmod((64'(m_base) << (WC * m_j)) ^ ((64'(m_word) >> (WD - WC * m_j)) << K));
        if (m_j == N) begin
          m_busy = 0;
          if (m_last) begin
            m_done  = 1;
            m_match = (m_crc == m_ref);
          end
        end
      end
      if (!was_busy && i_valid) begin
        m_busy = 1; m_j = 0; m_base = m_crc;
        m_word = i_data; m_last = i_last; m_ref = i_crc_ref;
      end
    end
  end

  logic run_cmp = 1'b0;
  always @(negedge i_clk) begin
    if (run_cmp && !i_rst) begin
      chk("crc",   32'(o_crc),   32'(m_crc));
      chk("ready", 32'(o_ready), 32'(!m_busy));
      chk("done",  32'(o_done),  32'(m_done));
      chk("match", 32'(o_match), 32'(m_match));
    end
  end

  task automatic do_start();
    i_start = 1;
    @(negedge i_clk);
    i_start = 0;
  endtask

  // Present a word and return at the negedge after the edge that accepted it.
  task automatic send(input logic [WD-1:0] d, input logic l, input logic [K-1:0] r);
    int b;
    b = 0;
    i_valid = 1; i_data = d; i_last = l; i_crc_ref = r;
    while (!o_ready && b < 50) begin
      @(negedge i_clk);
      b++;
    end
    if (b >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: o_ready never rose, word %0h", d);
    end
    @(negedge i_clk);
    i_valid = 0;
  endtask

  initial begin
    int t_prev;
    i_rst = 1; i_start = 0; i_valid = 0; i_data = '0; i_last = 0; i_crc_ref = '0;
    #2;
    chk("rst_crc",   32'(o_crc),   32'h0);
    chk("rst_ready", 32'(o_ready), 32'h1);
    chk("rst_done",  32'(o_done),  32'h0);
    chk("rst_match", 32'(o_match), 32'h0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 0;
    @(negedge i_clk);
    run_cmp = 1;

    // frame {0x01}
    do_start();
    send(8'h01, 1, 3'b000);
    chk("t1_ready_t0", 32'(o_ready), 32'h0);
    @(negedge i_clk);
    chk("t1_ready_t1", 32'(o_ready), 32'h0);
    chk("t1_done_t1",  32'(o_done),  32'h0);
    @(negedge i_clk);
    chk("t1_done", 32'(o_done),  32'h1);
    chk("t1_crc",  32'(o_crc),   32'h3);
    chk("t1_rdy",  32'(o_ready), 32'h1);

    // frames {0x80}, {0x81}
    do_start();
    send(8'h80, 1, 3'b000);
    repeat (2) @(negedge i_clk);
    chk("t2a_crc", 32'(o_crc), 32'h3);
    do_start();
    send(8'h81, 1, 3'b000);
    repeat (2) @(negedge i_clk);
    chk("t2b_crc",   32'(o_crc),   32'h0);
    chk("t2b_match", 32'(o_match), 32'h1);

    // two-word frames
    do_start();
    send(8'h01, 0, 3'b000);
    send(8'h00, 1, 3'b110);
    repeat (2) @(negedge i_clk);
    chk("t3a_crc",   32'(o_crc),   32'h6);
    chk("t3a_match", 32'(o_match), 32'h1);
    do_start();
    send(8'h01, 0, 3'b000);
    send(8'h00, 1, 3'b111);
    repeat (2) @(negedge i_clk);
    chk("t3b_crc",   32'(o_crc),   32'h6);
    chk("t3b_match", 32'(o_match), 32'h0);

    // abort after accepting 0xFF
    do_start();
    send(8'hFF, 1, 3'b000);
    do_start();
    chk("t4_crc",   32'(o_crc),   32'h0);
    chk("t4_ready", 32'(o_ready), 32'h1);
    chk("t4_done",  32'(o_done),  32'h0);
    @(negedge i_clk);
    chk("t4_done2", 32'(o_done),  32'h0);

    // back-to-back words: one acceptance per N+1 cycles
    do_start();
    t_prev = -1;
    for (int i = 0; i < 6; i++) begin
      send(8'(8'h3C + 17 * i), (i == 5), 3'b000);
      if (t_prev >= 0) chk("t5_interval", 32'(cyc - t_prev), 32'(N + 1));
      t_prev = cyc;
    end
    repeat (3) @(negedge i_clk);

    // async reset mid-word after a matching frame
    do_start();
    send(8'h81, 1, 3'b000);
    repeat (2) @(negedge i_clk);
    chk("t6_pre_match", 32'(o_match), 32'h1);
    send(8'h55, 1, 3'b000);
    #1 i_rst = 1;
    #1;
    chk("t6_crc",   32'(o_crc),   32'h0);
    chk("t6_ready", 32'(o_ready), 32'h1);
    chk("t6_done",  32'(o_done),  32'h0);
    chk("t6_match", 32'(o_match), 32'h0);
    #1 i_rst = 0;
    @(negedge i_clk);
    send(8'h01, 1, 3'b000);
    repeat (2) @(negedge i_clk);
    chk("t6_next_crc", 32'(o_crc), 32'h3);

    // random traffic, including starts that abort words in flight
    for (int i = 0; i < 600; i++) begin
      i_valid   = ($urandom_range(0, 3) != 0);
      i_data    = 8'($urandom);
      i_last    = ($urandom_range(0, 2) == 0);
      i_crc_ref = 3'($urandom);
      i_start   = ($urandom_range(0, 15) == 0);
      @(negedge i_clk);
    end
    i_valid = 0; i_start = 0;
    repeat (4) @(negedge i_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
